pwm_capture: RTL and testbench

PWM capture block: the receive-side counterpart of the team's PWM generator. It samples an asynchronous PWM input, measures period and high time in `ck` cycles, and publishes each completed measurement with a one-cycle `valid` strobe. It sits between an external or looped-back PWM pin and the control/readback logic. It also flags loss of edges (0 % / 100 % duty, or a dead line).

---
 rtl/pwm_pkg.sv | 13 +
 rtl/pwm_sync.sv | 22 ++
 rtl/pwm_capture.sv | 154 +++++++++++++++
 tb/tb_pwm_capture.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared PWM definitions: FSM state encoding and default counter width.
// Used by the PWM generator and the capture block.
package pwm_pkg;

  localparam int PWM_CW = 16;

  typedef enum logic [1:0] {
    IDLE,
    HIGH,
    LOW
  } pwm_state_t;

endpackage

// File: rtl/pwm_sync.sv
// Two-flop synchronizer for an asynchronous PWM line.
// Reusable for any single-bit PWM input.
module pwm_sync (
  input  logic ck,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic s1;

  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      q  <= 1'b0;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

endmodule

// File: rtl/pwm_capture.sv
// PWM capture: measures period and high time of pwm_in in ck cycles.
// Optional glitch filter: define PWM_CAPTURE_GLITCH_FILTER_EN.
module pwm_capture
  import pwm_pkg::*;
#(
  parameter int CW   = PWM_CW,
  parameter int FILT = 3
) (
  input  logic          ck,
  input  logic          rst_n,
  input  logic          pwm_in,
  output logic [CW-1:0] period,
  output logic [CW-1:0] high_time,
  output logic          valid,
  output logic          timeout,
  output logic          level
);

  localparam logic [CW-1:0] CMAX = '1;

  logic          s2;
  logic          lvl;
  logic          s3;
  logic          rise;
  logic          fall;
  logic          sat;
  logic [CW-1:0] cnt;
  logic [CW-1:0] hi_cap;
  logic          pub;
  logic          cap;
  logic          tmo;
  pwm_state_t    state;
  pwm_state_t    state_n;

  pwm_sync u_sync (
    .ck    (ck),
    .rst_n (rst_n),
    .d     (pwm_in),
    .q     (s2)
  );

`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
  localparam int FW = $clog2(FILT + 1);

  logic [FW-1:0] fcnt;
  logic          filt;

  // Level flips only after FILT consecutive disagreeing samples
  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      filt <= 1'b0;
      fcnt <= '0;
    end else if (s2 == filt) begin
      fcnt <= '0;
    end else if (fcnt == FW'(FILT - 1)) begin
      filt <= s2;
      fcnt <= '0;
    end else begin
      fcnt <= fcnt + 1'b1;
    end
  end

  assign lvl = filt;
`else
  localparam int unused_filt = FILT;

  assign lvl = s2;
`endif

  assign rise = lvl & ~s3;
  assign fall = ~lvl & s3;
  assign sat  = (cnt == CMAX);

  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      s3  <= 1'b0;
      cnt <= '0;
    end else begin
      s3 <= lvl;
      if (rise) begin
        cnt <= CW'(1);
      end else if (!sat) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // An edge in the saturation cycle takes priority over timeout
  always_comb begin
    state_n = state;
    pub     = 1'b0;
    cap     = 1'b0;
    tmo     = 1'b0;
    unique case (state)
      IDLE: begin
        if (rise) begin
          state_n = HIGH;
        end
      end
      HIGH: begin
        if (fall) begin
          cap     = 1'b1;
          state_n = LOW;
        end else if (sat) begin
          tmo     = 1'b1;
          state_n = IDLE;
        end
      end
      LOW: begin
        if (rise) begin
          pub     = 1'b1;
          state_n = HIGH;
        end else if (sat) begin
          tmo     = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      hi_cap    <= '0;
      period    <= '0;
      high_time <= '0;
      valid     <= 1'b0;
      timeout   <= 1'b0;
      level     <= 1'b0;
    end else begin
      valid   <= pub;
      timeout <= tmo;
      if (cap) begin
        hi_cap <= cnt;
      end
      if (pub) begin
        period    <= cnt;
        high_time <= hi_cap;
      end
      if (tmo) begin
        level <= s2;
      end
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// Scoreboard bench for pwm_capture (CW=8 so timeouts come quickly).
// Expected results are queued by stimulus and checked by a monitor.
module tb_pwm_capture;
  import pwm_pkg::*;

  localparam int CW = 8;

  logic          ck = 1'b0;
  logic          rst_n = 1'b0;
  logic          pwm_in = 1'b0;
  logic [CW-1:0] period;
  logic [CW-1:0] high_time;
  logic          valid;
  logic          timeout;
  logic          level;

  pwm_capture #(
    .CW   (CW),
    .FILT (3)
  ) dut (
    .ck        (ck),
    .rst_n     (rst_n),
    .pwm_in    (pwm_in),
    .period    (period),
    .high_time (high_time),
    .valid     (valid),
    .timeout   (timeout),
    .level     (level)
  );

  always #5 ck = ~ck;

  typedef struct {
    int p;
    int h;
    int gap;
  } exp_t;

  exp_t vq[$];
  bit   tq[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   last_v = 0;
  int   last_p = 0;
  int   last_h = 0;

  always @(posedge ck) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  task automatic pv(input int p, input int h, input int g);
    exp_t e;
    e.p = p;
    e.h = h;
    e.gap = g;
    vq.push_back(e);
  endtask

  task automatic drive(input logic v, input int n);
    pwm_in = v;
    repeat (n) @(posedge ck);
    #1;
  endtask

  task automatic wave(input int p, input int h, input int n);
    for (int i = 0; i < n; i++) begin
      drive(1'b1, h);
      drive(1'b0, p - h);
    end
  endtask

  always @(negedge ck) begin
    if (rst_n) begin
      if (valid) begin
        if (vq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected valid: got period=%0d high=%0d want none",
                   period, high_time);
        end else begin
          exp_t e;
          e = vq.pop_front();
          chk("period", int'(period), e.p);
          chk("high_time", int'(high_time), e.h);
          if (e.gap != 0) chk("valid gap", cyc - last_v, e.gap);
          last_p = e.p;
          last_h = e.h;
        end
        last_v = cyc;
      end
      if (timeout) begin
        if (tq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected timeout: got level=%0d want none", level);
        end else begin
          bit l;
          l = tq.pop_front();
          chk("timeout level", int'(level), int'(l));
          chk("hold period", int'(period), last_p);
          chk("hold high_time", int'(high_time), last_h);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    repeat (3) @(posedge ck);
    #1;
    chk("rst period", int'(period), 0);
    chk("rst high_time", int'(high_time), 0);
    chk("rst valid", int'(valid), 0);
    chk("rst timeout", int'(timeout), 0);
    chk("rst level", int'(level), 0);
    chk("rst state", int'(dut.state), int'(IDLE));
    rst_n = 1'b1;
    drive(1'b0, 5);

    pv(10, 3, 0);
    repeat (4) pv(10, 3, 10);
    repeat (2) pv(20, 15, 20);
    wave(10, 3, 5);
    wave(20, 15, 3);

    tq.push_back(1'b0);
    drive(1'b0, 300);
    tq.push_back(1'b1);
    drive(1'b1, 300);
    drive(1'b1, 300);
    chk("timeouts seen", tq.size(), 0);
    chk("idle after timeout", int'(dut.state), int'(IDLE));

    drive(1'b0, 5);
    pv(10, 3, 0);
    wave(10, 3, 2);
    tq.push_back(1'b0);
    drive(1'b0, 300);

    drive(1'b1, 3);
    drive(1'b0, 4);
    rst_n = 1'b0;
    #1;
    chk("async rst period", int'(period), 0);
    chk("async rst high_time", int'(high_time), 0);
    chk("async rst valid", int'(valid), 0);
    chk("async rst timeout", int'(timeout), 0);
    chk("async rst level", int'(level), 0);
    last_p = 0;
    last_h = 0;
    repeat (2) @(posedge ck);
    #1;
    rst_n = 1'b1;
    drive(1'b0, 3);
    pv(10, 3, 0);
    wave(10, 3, 2);
    tq.push_back(1'b0);
    drive(1'b0, 300);

`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
    pv(10, 3, 0);
    repeat (3) pv(10, 3, 10);
`else
    pv(10, 3, 0);
    pv(10, 3, 10);
    pv(6, 3, 6);
    pv(4, 1, 4);
    pv(10, 3, 10);
`endif
    wave(10, 3, 2);
    drive(1'b1, 3);
    drive(1'b0, 3);
    drive(1'b1, 1);
    drive(1'b0, 3);
    drive(1'b1, 3);
    drive(1'b0, 7);
    wave(10, 3, 1);
    tq.push_back(1'b0);
    drive(1'b0, 300);

    pv(2, 1, 0);
    repeat (4) pv(2, 1, 2);
    wave(2, 1, 6);
    tq.push_back(1'b0);
    drive(1'b0, 300);

    for (int i = 0; i < 50 && (vq.size() != 0 || tq.size() != 0); i++) begin
      @(posedge ck);
    end
    chk("valid queue drained", vq.size(), 0);
    chk("timeout queue drained", tq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
